// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle multiply; divide is always iterative.
module mdu_hilo (
   input  logic        clk,
   input  logic        rst,
   input  logic        mult_en_e,
   input  logic        div_en_e,
   input  logic        unsigned_instr_e,
   input  logic [31:0] srcA_e,
   input  logic [31:0] srcB_e,
   input  logic        hi_write_e,
   input  logic        lo_write_e,
   input  logic [1:0]  hi_src_e,
   input  logic [1:0]  lo_src_e,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        done_o
);

`ifdef MDU_FAST_MULT_EN
   typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;
`else
   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`endif

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] mag_b_q;
   logic [31:0] a_raw_q;
   logic        res_neg_q;
   logic        rem_neg_q;
   logic        div_zero_q;
   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        sign_a, sign_b;
   logic [31:0] abs_a, abs_b;
   logic [32:0] rem_shift, trial;
   logic        sub_ok;
   logic [31:0] quo_fix, rem_fix;
   logic [31:0] fix_hi, fix_lo;

`ifdef MDU_FAST_MULT_EN
   logic [63:0] ext_a, ext_b, prod_fast;
`else
   logic [31:0] mag_a_q;
   logic        op_div_q;
   logic [63:0] acc_q;
   logic [63:0] addend, prod_fix;
`endif

   always_comb begin
      sign_a = ~unsigned_instr_e & srcA_e[31];
      sign_b = ~unsigned_instr_e & srcB_e[31];
      abs_a  = sign_a ? (~srcA_e + 32'd1) : srcA_e;
      abs_b  = sign_b ? (~srcB_e + 32'd1) : srcB_e;
`ifdef MDU_FAST_MULT_EN
      // Low 64 bits of the extended product are correct for both signednesses.
      ext_a     = {{32{sign_a}}, srcA_e};
      ext_b     = {{32{sign_b}}, srcB_e};
      prod_fast = ext_a * ext_b;
`endif
   end

   // Restoring divide step: dividend bits stream out of quo_q's MSB as quotient bits enter.
   always_comb begin
      rem_shift = {rem_q, quo_q[31]};
      trial     = rem_shift - {1'b0, mag_b_q};
      sub_ok    = rem_shift[32] | ~trial[32];
   end

   always_comb begin
      quo_fix = res_neg_q ? (~quo_q + 32'd1) : quo_q;
      rem_fix = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
      if (div_zero_q) begin
         fix_hi = a_raw_q;
         fix_lo = 32'hFFFF_FFFF;
      end else begin
         fix_hi = rem_fix;
         fix_lo = quo_fix;
      end
`ifndef MDU_FAST_MULT_EN
      addend   = mag_b_q[cnt_q] ? ({32'd0, mag_a_q} << cnt_q) : 64'd0;
      prod_fix = res_neg_q ? (~acc_q + 64'd1) : acc_q;
      if (!op_div_q) begin
         fix_hi = prod_fix[63:32];
         fix_lo = prod_fix[31:0];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         mag_b_q    <= 32'd0;
         a_raw_q    <= 32'd0;
         res_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         quo_q      <= 32'd0;
         rem_q      <= 32'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         done_q     <= 1'b0;
`ifndef MDU_FAST_MULT_EN
         mag_a_q    <= 32'd0;
         op_div_q   <= 1'b0;
         acc_q      <= 64'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (hi_write_e && hi_src_e == 2'b01) hi_q <= srcA_e;
               if (lo_write_e && lo_src_e == 2'b01) lo_q <= srcA_e;
               if (div_en_e || mult_en_e) begin
                  mag_b_q    <= abs_b;
                  a_raw_q    <= srcA_e;
                  res_neg_q  <= sign_a ^ sign_b;
                  rem_neg_q  <= sign_a;
                  div_zero_q <= (srcB_e == 32'd0);
                  cnt_q      <= 5'd0;
                  quo_q      <= abs_a;
                  rem_q      <= 32'd0;
`ifndef MDU_FAST_MULT_EN
                  mag_a_q    <= abs_a;
                  acc_q      <= 64'd0;
`endif
               end
               if (div_en_e) begin
                  state_q <= StDiv;
`ifndef MDU_FAST_MULT_EN
                  op_div_q <= 1'b1;
`endif
               end else if (mult_en_e) begin
`ifdef MDU_FAST_MULT_EN
                  hi_q   <= prod_fast[63:32];
                  lo_q   <= prod_fast[31:0];
                  done_q <= 1'b1;
`else
                  state_q  <= StMul;
                  op_div_q <= 1'b0;
`endif
               end
            end
`ifndef MDU_FAST_MULT_EN
            StMul: begin
               acc_q <= acc_q + addend;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= StFix;
            end
`endif
            StDiv: begin
               quo_q <= {quo_q[30:0], sub_ok};
               rem_q <= sub_ok ? trial[31:0] : rem_shift[31:0];
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= StFix;
            end
            StFix: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q != StIdle);
   assign done_o = done_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: table of multiply/divide vectors plus
// directed MTHI/MTLO, busy-ignore and mid-divide reset sequences.
module tb_mdu_hilo;

   logic        clk;
   logic        rst;
   logic        mult_en_e;
   logic        div_en_e;
   logic        unsigned_instr_e;
   logic [31:0] srcA_e;
   logic [31:0] srcB_e;
   logic        hi_write_e;
   logic        lo_write_e;
   logic [1:0]  hi_src_e;
   logic [1:0]  lo_src_e;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   mdu_hilo dut (
      .clk              (clk),
      .rst              (rst),
      .mult_en_e        (mult_en_e),
      .div_en_e         (div_en_e),
      .unsigned_instr_e (unsigned_instr_e),
      .srcA_e           (srcA_e),
      .srcB_e           (srcB_e),
      .hi_write_e       (hi_write_e),
      .lo_write_e       (lo_write_e),
      .hi_src_e         (hi_src_e),
      .lo_src_e         (lo_src_e),
      .hi_o             (hi_o),
      .lo_o             (lo_o),
      .busy_o           (busy_o),
      .done_o           (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // op: 0 = mult, 1 = div, 2 = both enables (divide must win)
   typedef struct {
      string       name;
      logic [1:0]  op;
      logic        uns;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   localparam int NumVec = 12;
   vec_t vecs [NumVec];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Start an op at the next edge (T0) and wait for done_o; lat counts edges after T0.
   task automatic run_op(input logic [1:0] op, input logic uns, input logic [31:0] a,
                         input logic [31:0] b, input bit inject, output int lat,
                         output int bcnt);
      @(negedge clk);
      mult_en_e        = (op != 2'd1);
      div_en_e         = (op != 2'd0);
      unsigned_instr_e = uns;
      srcA_e           = a;
      srcB_e           = b;
      @(posedge clk);
      #1;
      mult_en_e = 1'b0;
      div_en_e  = 1'b0;
      lat  = 0;
      bcnt = busy_o ? 1 : 0;
      while (!done_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy_o) bcnt++;
         if (inject && lat == 5) begin
            hi_write_e       = 1'b1;
            hi_src_e         = 2'b01;
            srcA_e           = 32'hDEAD_BEEF;
            srcB_e           = 32'd3;
            unsigned_instr_e = 1'b0;
            mult_en_e        = 1'b1;
         end
         if (inject && lat == 6) begin
            hi_write_e = 1'b0;
            hi_src_e   = 2'b00;
            mult_en_e  = 1'b0;
         end
      end
   endtask

   int lat, bcnt, exp_lat, dcnt;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{"mult_neg3x5",     2'd0, 1'b0, 32'hFFFF_FFFD, 32'd5,
                   32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1]  = '{"multu_ffx2",      2'd0, 1'b1, 32'hFFFF_FFFF, 32'd2,
                   32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2]  = '{"mult_m1xm1",      2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h0000_0000, 32'h0000_0001};
      vecs[3]  = '{"mult_maxxmin",    2'd0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000,
                   32'hC000_0000, 32'h8000_0000};
      vecs[4]  = '{"multu_minxmin",   2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000,
                   32'h4000_0000, 32'h0000_0000};
      vecs[5]  = '{"div_neg7d2",      2'd1, 1'b0, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[6]  = '{"divu_100d7",      2'd1, 1'b1, 32'd100,       32'd7,
                   32'd2,         32'd14};
      vecs[7]  = '{"div_7dneg2",      2'd1, 1'b0, 32'd7,         32'hFFFF_FFFE,
                   32'd1,         32'hFFFF_FFFD};
      vecs[8]  = '{"div_by_zero",     2'd1, 1'b1, 32'h1234_5678, 32'd0,
                   32'h1234_5678, 32'hFFFF_FFFF};
      vecs[9]  = '{"div_by_zero_sgn", 2'd1, 1'b0, 32'h8000_0001, 32'd0,
                   32'h8000_0001, 32'hFFFF_FFFF};
      vecs[10] = '{"div_min_dm1",     2'd1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'd0,         32'h8000_0000};
      vecs[11] = '{"both_div_wins",   2'd2, 1'b1, 32'd100,       32'd7,
                   32'd2,         32'd14};

      rst = 1'b1;
      mult_en_e = 1'b0; div_en_e = 1'b0; unsigned_instr_e = 1'b0;
      srcA_e = 32'd0; srcB_e = 32'd0;
      hi_write_e = 1'b0; lo_write_e = 1'b0; hi_src_e = 2'b00; lo_src_e = 2'b00;

      @(posedge clk);
      #1;
      check("reset_hi",   {32'd0, hi_o}, 64'd0);
      check("reset_lo",   {32'd0, lo_o}, 64'd0);
      check("reset_busy", {63'd0, busy_o}, 64'd0);
      check("reset_done", {63'd0, done_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NumVec; i++) begin
         run_op(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
`ifdef MDU_FAST_MULT_EN
         exp_lat = (vecs[i].op == 2'd0) ? 0 : 33;
`else
         exp_lat = 33;
`endif
         check({vecs[i].name, "_hi"},   {32'd0, hi_o}, {32'd0, vecs[i].hi});
         check({vecs[i].name, "_lo"},   {32'd0, lo_o}, {32'd0, vecs[i].lo});
         check({vecs[i].name, "_lat"},  64'(lat),  64'(exp_lat));
         check({vecs[i].name, "_busy"}, 64'(bcnt), 64'(exp_lat));
         @(posedge clk);
         #1;
         check({vecs[i].name, "_done_pulse"}, {63'd0, done_o}, 64'd0);
      end

      // MTHI / MTLO in IDLE, independent, visible the next cycle
      @(negedge clk);
      hi_write_e = 1'b1; hi_src_e = 2'b01; srcA_e = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      hi_write_e = 1'b0; hi_src_e = 2'b00;
      check("mthi_hi", {32'd0, hi_o}, {32'd0, 32'hCAFE_F00D});
      check("mthi_lo_kept", {32'd0, lo_o}, {32'd0, 32'h0000_000E});
      @(negedge clk);
      lo_write_e = 1'b1; lo_src_e = 2'b01; srcA_e = 32'h0BAD_BEEF;
      @(posedge clk);
      #1;
      lo_write_e = 1'b0; lo_src_e = 2'b00;
      check("mtlo_lo", {32'd0, lo_o}, {32'd0, 32'h0BAD_BEEF});
      check("mtlo_hi_kept", {32'd0, hi_o}, {32'd0, 32'hCAFE_F00D});
      // src 00 and 1x are not direct writes
      @(negedge clk);
      hi_write_e = 1'b1; hi_src_e = 2'b00; lo_write_e = 1'b1; lo_src_e = 2'b10;
      srcA_e = 32'h1234_5678;
      @(posedge clk);
      #1;
      hi_write_e = 1'b0; lo_write_e = 1'b0; lo_src_e = 2'b00;
      check("nowrite_hi", {32'd0, hi_o}, {32'd0, 32'hCAFE_F00D});
      check("nowrite_lo", {32'd0, lo_o}, {32'd0, 32'h0BAD_BEEF});
      check("nowrite_busy", {63'd0, busy_o}, 64'd0);

      // MTHI and MULT while busy are ignored
      run_op(2'd1, 1'b1, 32'd100, 32'd7, 1'b1, lat, bcnt);
      check("busy_mthi_hi",  {32'd0, hi_o}, 64'd2);
      check("busy_mthi_lo",  {32'd0, lo_o}, 64'd14);
      check("busy_mthi_lat", 64'(lat), 64'd33);
      @(posedge clk);
      #1;
      check("busy_mthi_idle", {63'd0, busy_o}, 64'd0);
      check("busy_mthi_hi_after", {32'd0, hi_o}, 64'd2);

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      div_en_e = 1'b1; unsigned_instr_e = 1'b1; srcA_e = 32'd1000; srcB_e = 32'd3;
      @(posedge clk);
      #1;
      div_en_e = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_hi",   {32'd0, hi_o}, 64'd0);
      check("rst_mid_lo",   {32'd0, lo_o}, 64'd0);
      check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
      check("rst_mid_done", {63'd0, done_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done_o || busy_o) dcnt++;
      end
      check("rst_no_done", 64'(dcnt), 64'd0);
      check("rst_hi_stays", {32'd0, hi_o}, 64'd0);

      run_op(2'd1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt);
      check("post_rst_hi",  {32'd0, hi_o}, {32'd0, 32'hFFFF_FFFF});
      check("post_rst_lo",  {32'd0, lo_o}, {32'd0, 32'hFFFF_FFFD});
      check("post_rst_lat", 64'(lat), 64'd33);
      check("post_rst_busy", 64'(bcnt), 64'd33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Execute-stage multiply/divide unit with the architectural HI/LO registers, sitting directly downstream of the decode-to-execute pipeline registers. It consumes the execute-stage control bits `mult_en_e`, `div_en_e`, `hi_write_e`, `lo_write_e`, `hi_src_e`, `lo_src_e` and `unsigned_instr_e`, together with the forwarded operands. Division, and multiplication in the default build, run iteratively, and `busy_o` tells the hazard unit to hold HI/LO consumers. It also implements MTHI/MTLO direct writes and provides HI/LO for MFHI/MFLO.

## Interface
Parameters: none.

Ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- mult_en_e  in  1  start a MULT/MULTU
- div_en_e  in  1  start a DIV/DIVU
- unsigned_instr_e  in  1  1 = unsigned operation, 0 = signed
- srcA_e  in  32  forwarded rs operand: multiplicand/dividend, or MTHI/MTLO data
- srcB_e  in  32  forwarded rt operand: multiplier/divisor
- hi_write_e  in  1  HI write request
- lo_write_e  in  1  LO write request
- hi_src_e  in  2  HI source select: 00 MDU result, 01 srcA_e, 1x no write
- lo_src_e  in  2  LO source select, same encoding as `hi_src_e`
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle pulse when a result is written to HI/LO

## Operation
- States:
  - IDLE
  - MUL: iterative shift-add
  - DIV: restoring, one quotient bit per cycle
  - FIX: sign correction and HI/LO write
- Start conditions, evaluated in IDLE only:
  - `div_en_e` → DIV.
  - `mult_en_e` → MUL.
  - Both asserted: DIV wins.
- At start:
  - Latch operand magnitudes, the result sign, the remainder sign and `unsigned_instr_e`.
  - Clear the 5-bit iteration counter.
- Signed mode: operands are converted to magnitudes (|0x80000000| = 2^31 in 32 bits unsigned).
- Result signs:
  - Product and quotient sign = signA XOR signB.
  - Remainder sign = signA.
- MUL state:
  - 64-bit accumulator; each cycle add (multiplicand << i) when bit i of the multiplier is set.
  - 32 cycles, then FIX.
- DIV state:
  - 33-bit partial remainder; shift in the next dividend bit; subtract the divisor if the result is non-negative; set the quotient bit.
  - 32 cycles, then FIX.
- FIX state:
  - Negate the results as required.
  - MUL result: HI = product[63:32], LO = product[31:0].
  - DIV result: LO = quotient, HI = remainder.
  - Pulse `done_o`, return to IDLE.
- Divide by zero: HI = srcA_e as latched, LO = 32'hFFFFFFFF, in both signed and unsigned modes. Same latency as a normal divide.
- 0x80000000 / −1 (signed): LO = 0x80000000, HI = 0.
- Direct writes (MTHI/MTLO):
  - Occur in IDLE when `hi_write_e` is set with `hi_src_e` = 01, and likewise for LO.
  - Write takes effect on the next edge. HI and LO are independent.
- `*_write_e` with `*_src_e` = 00 is informational: the unit itself writes HI/LO at FIX.
- While not IDLE:
  - `mult_en_e`, `div_en_e` and direct writes are ignored.
  - The hazard unit must stall such instructions using `busy_o`.
- `busy_o` = (state != IDLE).

## Timing
- Reset (asynchronous, any state including mid-operation): state IDLE, counter 0, `hi_o` = 0, `lo_o` = 0, `busy_o` = 0, `done_o` = 0. The in-flight operation is discarded.
- Iterative op accepted at edge T0:
  - `busy_o` is high after T0 through T33.
  - HI/LO are updated and `done_o` is high after edge T33, i.e. 33 cycles after acceptance.
  - `busy_o` is low after T33, so a back-to-back start is possible at T34.
- MFHI/MFLO read `hi_o`/`lo_o` directly. A value written at edge Tn is visible in cycle n+1, with no internal bypass.
- Outputs are all registered; `busy_o` decodes from the state register only.

## Configuration
- Macro: `MDU_FAST_MULT_EN`.
- Defined:
  - Multiply is a single-cycle 64-bit `*` (signed or unsigned per `unsigned_instr_e`).
  - HI/LO are written and `done_o` pulses at the accepting edge T0.
  - `busy_o` is never asserted for multiply, and the MUL state is not compiled in.
- Undefined: iterative 33-cycle multiply as described above.
- Divide behaviour is identical in both builds.

## Test plan
- Signed MULT with srcA = 0xFFFFFFFD (−3), srcB = 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, `done_o` at T33 (at T0 with `MDU_FAST_MULT_EN`).
- MULTU with 0xFFFFFFFF × 2 → HI = 0x00000001, LO = 0xFFFFFFFE.
- Signed DIV with srcA = 0xFFFFFFF9 (−7), srcB = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2. `busy_o` high for exactly 33 cycles.
- DIV 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI 0xCAFEF00D and MTLO 0x0BADBEEF in IDLE → visible next cycle. An MTHI asserted while `busy_o` is high → ignored.
- Assert `rst` at cycle 10 of a DIV → `hi_o` = `lo_o` = 0 and `busy_o` = 0 immediately, no `done_o`. A new DIV after `rst` drops completes correctly.
